match_controller: RTL and testbench
===================================

MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 Parameter NUM_PLAYERS, default 2: number of players, legal range 2..4.
REQ-002 Parameter WIN_SCORE, default 5: points needed to win a match, legal range 1..15.
REQ-003 Parameter ROUND_TICKS, default 9: round length in Tick strobes, legal range 1..15.
REQ-004 Parameter READY_TICKS, default 1; DIVEKICK_TICKS, default 1; PAUSE_TICKS, default 2: phase durations in Tick strobes, each legal range 1..15.
REQ-005 Clk  input  1  system clock; all state changes on its rising edge.
REQ-006 Reset  input  1  asynchronous, active-low reset; asserts immediately, releases synchronously to Clk.
REQ-007 Tick  input  1  one-cycle timebase strobe.
REQ-008 Start_Pressed  input  1  level; begin or continue play.
REQ-009 Confirm_Pressed  input  1  level; leave the victory screen.
REQ-010 Hit_Detected  input  NUM_PLAYERS  bit i high means player i landed a scoring hit.
REQ-011 gameState  output  4  state code: Title=0, Playing=3, Pause=4, Reset_State=5, Pause_2=6, Victory=7, Ready=8, DiveKick=9.
REQ-012 Round_Time  output  4  remaining round ticks.
REQ-013 Scores  output  4*NUM_PLAYERS  packed; player i occupies bits [4i+3:4i].
REQ-014 Round_Num  output  4  current round number, 1-based.
REQ-015 Winner  output  2  winning player index, valid only in Victory.
REQ-016 Draw  output  1  high in Victory when two or more players reach WIN_SCORE on the same point.

Function
REQ-017 Title -> Ready on Start_Pressed; scores cleared, Round_Num=1.
REQ-018 Ready, DiveKick and Pause_2 each load a phase counter with their duration on entry, decrement it on each Tick, and exit on the Tick that brings it to 0.
REQ-019 Ready exits to DiveKick; DiveKick exits to Playing; on entry to Playing, Round_Time is loaded with ROUND_TICKS.
REQ-020 Playing decrements Round_Time on each Tick, saturating at 0.
REQ-021 Playing -> Pause when any Hit_Detected bit is high or Round_Time==0; Hit_Detected is latched on the same edge.
REQ-022 A hit and a timeout in the same cycle are treated as a hit.
REQ-023 Pause lasts exactly one cycle: each player with a latched hit gets +1, saturating at WIN_SCORE; Pause then goes to Pause_2.
REQ-024 A timeout with no hit awards no points.
REQ-025 Pause_2 exits to Reset_State.
REQ-026 Reset_State goes to Victory if any score equals WIN_SCORE; this takes priority over Start_Pressed.
REQ-027 Otherwise, Reset_State goes to Ready on Start_Pressed and Round_Num increments, saturating at 15.
REQ-028 Victory: Winner is the lowest index with score equal to WIN_SCORE; Draw=1 if more than one player has that score.
REQ-029 Victory -> Title on Confirm_Pressed.
REQ-030 Outside Playing, Hit_Detected is ignored; outside the timed states, Tick is ignored.
REQ-031 Any illegal state encoding goes to Title on the next edge.

Reset
REQ-032 Reset low forces: state Title, gameState=0, Scores=0, Round_Time=0, Round_Num=0, Winner=0, Draw=0, phase counter=0, hit latch=0.
REQ-033 Reset asserted in any state, including mid-Pause, discards the pending point award.

Configuration
REQ-034 Macro DOUBLE_HIT_EN: when defined, simultaneous hits by several players in the same cycle award +1 to each of them.
REQ-035 When DOUBLE_HIT_EN is not defined, a latched hit vector with more than one bit set is a trade: no points are awarded, and the flow is otherwise unchanged.

Verification
REQ-036 NUM_PLAYERS=2, defaults: Start, then 1 Tick, 1 Tick -> gameState 8->9->3 with Round_Time=9.
REQ-037 In Playing, Hit_Detected=2'b01 -> Pause for one cycle, then Scores[3:0]=1 and gameState=6; after 2 Ticks gameState=5.
REQ-038 In Playing, 9 Ticks with no hit -> Round_Time=0, Pause, Scores unchanged, Round_Num stays 1 until Start.
REQ-039 Both scores at 4 with Hit_Detected=2'b11: with DOUBLE_HIT_EN, both scores become 5, Victory, Draw=1, Winner=0; without it, scores stay 4 and the flow returns to Reset_State.
REQ-040 Player 1 at 5 in Reset_State with Start_Pressed held -> Victory, Winner=1; Confirm_Pressed -> Title; next Start -> Scores=0, Round_Num=1.
REQ-041 Reset driven low during Pause_2 -> all outputs zero immediately, without waiting for a clock edge; after release, state is Title.

Source files
------------

// File: rtl/match_controller_if.sv
// Bus interface for match_controller: player/timebase inputs and scoreboard outputs.
// The master modport drives the inputs (game front end); the slave modport is the controller.
// All inputs are plain levels or one-cycle strobes sampled on the rising edge of Clk; there is
// no backpressure on this bus, so no valid/ready pair is involved.
interface match_controller_if #(
  parameter int NUM_PLAYERS = 2
);
  logic                     Tick;
  logic                     Start_Pressed;
  logic                     Confirm_Pressed;
  logic [NUM_PLAYERS-1:0]   Hit_Detected;
  logic [3:0]               gameState;
  logic [3:0]               Round_Time;
  logic [4*NUM_PLAYERS-1:0] Scores;
  logic [3:0]               Round_Num;
  logic [1:0]               Winner;
  logic                     Draw;

  modport master (
    output Tick, Start_Pressed, Confirm_Pressed, Hit_Detected,
    input  gameState, Round_Time, Scores, Round_Num, Winner, Draw
  );

  modport slave (
    input  Tick, Start_Pressed, Confirm_Pressed, Hit_Detected,
    output gameState, Round_Time, Scores, Round_Num, Winner, Draw
  );
endinterface

// File: rtl/match_controller.sv
// match_controller: round/score sequencer for a 2..4 player fighting match.
// Flow: Title -> Ready -> DiveKick -> Playing -> Pause -> Pause_2 -> Reset_State
//       -> (Ready for the next round | Victory -> Title).
// Optional feature macro DOUBLE_HIT_EN: when defined, simultaneous hits award a point to
// every hitting player; when undefined, a multi-player hit is a trade and awards nothing.
// The FSM state is visible directly on gameState.
module match_controller #(
  parameter int NUM_PLAYERS    = 2,
  parameter int WIN_SCORE      = 5,
  parameter int ROUND_TICKS    = 9,
  parameter int READY_TICKS    = 1,
  parameter int DIVEKICK_TICKS = 1,
  parameter int PAUSE_TICKS    = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  match_controller_if.slave    bus
);

  typedef enum logic [3:0] {
    TITLE       = 4'd0,
    PLAYING     = 4'd3,
    PAUSE       = 4'd4,
    RESET_STATE = 4'd5,
    PAUSE_2     = 4'd6,
    VICTORY     = 4'd7,
    READY       = 4'd8,
    DIVEKICK    = 4'd9
  } state_t;

  localparam logic [3:0] WIN4 = 4'(WIN_SCORE);

  state_t                   state_q, state_d;
  logic [3:0]               phase_q, phase_d;
  logic [3:0]               round_time_q, round_time_d;
  logic [4*NUM_PLAYERS-1:0] scores_q, scores_d;
  logic [3:0]               round_num_q, round_num_d;
  logic [NUM_PLAYERS-1:0]   hit_q, hit_d;
  logic [NUM_PLAYERS-1:0]   award;
  logic [1:0]               winner_idx;
  logic [2:0]               win_cnt;
  logic                     any_win;

  // Find the lowest-index player at WIN_SCORE and how many players are there.
  always_comb begin
    winner_idx = 2'd0;
    win_cnt    = 3'd0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (scores_q[4*i +: 4] == WIN4) begin
        winner_idx = 2'(i);
        win_cnt    = win_cnt + 3'd1;
      end
    end
    any_win = (win_cnt != 3'd0);
  end

  // Players that earn a point from the latched hit vector.
  always_comb begin
    award = '0;
`ifdef DOUBLE_HIT_EN
    award = hit_q;
`else
    // More than one simultaneous hit is a trade: nobody scores.
    if ($countones(hit_q) == 1) award = hit_q;
`endif
  end

  // Next-state and datapath updates; every register holds unless a state changes it.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    round_time_d = round_time_q;
    scores_d     = scores_q;
    round_num_d  = round_num_q;
    hit_d        = hit_q;
    case (state_q)
      TITLE: begin
        if (bus.Start_Pressed) begin
          state_d     = READY;
          scores_d    = '0;
          round_num_d = 4'd1;
          phase_d     = 4'(READY_TICKS);
        end
      end
      READY: begin
        if (bus.Tick) begin
          phase_d = phase_q - 4'd1;
          if (phase_q == 4'd1) begin
            state_d = DIVEKICK;
            phase_d = 4'(DIVEKICK_TICKS);
          end
        end
      end
      DIVEKICK: begin
        if (bus.Tick) begin
          phase_d = phase_q - 4'd1;
          if (phase_q == 4'd1) begin
            state_d      = PLAYING;
            round_time_d = 4'(ROUND_TICKS);
          end
        end
      end
      PLAYING: begin
        if (bus.Tick && round_time_q != 4'd0) round_time_d = round_time_q - 4'd1;
        // A hit wins over a timeout seen in the same cycle.
        if (|bus.Hit_Detected) begin
          state_d = PAUSE;
          hit_d   = bus.Hit_Detected;
        end else if (round_time_q == 4'd0) begin
          state_d = PAUSE;
          hit_d   = '0;
        end
      end
      PAUSE: begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          if (award[i] && scores_q[4*i +: 4] != WIN4)
            scores_d[4*i +: 4] = scores_q[4*i +: 4] + 4'd1;
        end
        hit_d   = '0;
        state_d = PAUSE_2;
        phase_d = 4'(PAUSE_TICKS);
      end
      PAUSE_2: begin
        if (bus.Tick) begin
          phase_d = phase_q - 4'd1;
          if (phase_q == 4'd1) state_d = RESET_STATE;
        end
      end
      RESET_STATE: begin
        if (any_win) begin
          state_d = VICTORY;
        end else if (bus.Start_Pressed) begin
          state_d     = READY;
          phase_d     = 4'(READY_TICKS);
          round_num_d = (round_num_q == 4'd15) ? 4'd15 : round_num_q + 4'd1;
        end
      end
      VICTORY: begin
        if (bus.Confirm_Pressed) state_d = TITLE;
      end
      default: state_d = TITLE;
    endcase
  end

  // State and datapath registers; reset clears everything, including a pending award.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= TITLE;
      phase_q      <= 4'd0;
      round_time_q <= 4'd0;
      scores_q     <= '0;
      round_num_q  <= 4'd0;
      hit_q        <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      round_time_q <= round_time_d;
      scores_q     <= scores_d;
      round_num_q  <= round_num_d;
      hit_q        <= hit_d;
    end
  end

  assign bus.gameState  = state_q;
  assign bus.Round_Time = round_time_q;
  assign bus.Scores     = scores_q;
  assign bus.Round_Num  = round_num_q;
  assign bus.Winner     = (state_q == VICTORY) ? winner_idx : 2'd0;
  assign bus.Draw       = (state_q == VICTORY) && (win_cnt > 3'd1);

endmodule

// File: tb/tb_match_controller.sv
// Directed testbench for match_controller (NUM_PLAYERS=2, default timings).
module tb_match_controller;

  logic Clk;
  logic Reset;
  int   n_checks;
  int   n_fail;
  logic [3:0] exp_q[$];

  match_controller_if #(.NUM_PLAYERS(2)) bus ();

  match_controller #(.NUM_PLAYERS(2)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Clock and reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick();
    bus.Tick = 1'b1;
    step();
    bus.Tick = 1'b0;
  endtask

  task automatic press_start();
    bus.Start_Pressed = 1'b1;
    step();
    bus.Start_Pressed = 1'b0;
  endtask

  // From Reset_State: play one full round ending with hit vector h, back to Reset_State.
  task automatic play_round(input logic [1:0] h);
    press_start();
    tick();
    tick();
    bus.Hit_Detected = h;
    step();
    bus.Hit_Detected = 2'b00;
    step();
    tick();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.Tick = 1'b0;
    bus.Start_Pressed = 1'b0;
    bus.Confirm_Pressed = 1'b0;
    bus.Hit_Detected = 2'b00;
    Reset = 1'b0;
    step();
    step();
    check("rst_state", 32'(bus.gameState), 0);
    check("rst_scores", 32'(bus.Scores), 0);
    check("rst_round_num", 32'(bus.Round_Num), 0);
    check("rst_round_time", 32'(bus.Round_Time), 0);
    Reset = 1'b1;
    step();
    check("title_hold", 32'(bus.gameState), 0);

    // Title -> Ready -> DiveKick -> Playing
    exp_q.push_back(4'd8);
    exp_q.push_back(4'd9);
    exp_q.push_back(4'd3);
    press_start();
    check("walk_ready", 32'(bus.gameState), 32'(exp_q.pop_front()));
    check("round_num_1", 32'(bus.Round_Num), 1);
    tick();
    check("walk_divekick", 32'(bus.gameState), 32'(exp_q.pop_front()));
    tick();
    check("walk_playing", 32'(bus.gameState), 32'(exp_q.pop_front()));
    check("round_time_load", 32'(bus.Round_Time), 9);

    // Player 0 scores
    bus.Hit_Detected = 2'b01;
    step();
    bus.Hit_Detected = 2'b00;
    check("pause_state", 32'(bus.gameState), 4);
    check("pause_scores_pending", 32'(bus.Scores), 0);
    step();
    check("pause2_state", 32'(bus.gameState), 6);
    check("p0_scored", 32'(bus.Scores), 32'h01);
    tick();
    check("pause2_one_tick", 32'(bus.gameState), 6);
    tick();
    check("reset_state", 32'(bus.gameState), 5);

    // Ignored inputs in Reset_State
    bus.Hit_Detected = 2'b10;
    bus.Tick = 1'b1;
    step();
    bus.Hit_Detected = 2'b00;
    bus.Tick = 1'b0;
    check("ignore_state", 32'(bus.gameState), 5);
    check("ignore_scores", 32'(bus.Scores), 32'h01);

    // Round 2: timeout with no hit
    press_start();
    check("round_num_2", 32'(bus.Round_Num), 2);
    tick();
    tick();
    for (int i = 0; i < 9; i++) tick();
    check("timeout_round_time", 32'(bus.Round_Time), 0);
    check("timeout_still_playing", 32'(bus.gameState), 3);
    step();
    check("timeout_pause", 32'(bus.gameState), 4);
    step();
    tick();
    tick();
    check("timeout_reset_state", 32'(bus.gameState), 5);
    check("timeout_no_points", 32'(bus.Scores), 32'h01);
    step();
    step();
    check("round_num_holds", 32'(bus.Round_Num), 2);

    // Bring both players to 4
    for (int i = 0; i < 3; i++) play_round(2'b01);
    for (int i = 0; i < 4; i++) play_round(2'b10);
    check("both_at_4", 32'(bus.Scores), 32'h44);
    check("round_num_9", 32'(bus.Round_Num), 9);

    // Simultaneous hit
    play_round(2'b11);
`ifdef DOUBLE_HIT_EN
    check("double_scores", 32'(bus.Scores), 32'h55);
    step();
    check("double_victory", 32'(bus.gameState), 7);
    check("double_draw", 32'(bus.Draw), 1);
    check("double_winner", 32'(bus.Winner), 0);
`else
    check("trade_scores", 32'(bus.Scores), 32'h44);
    check("trade_reset_state", 32'(bus.gameState), 5);
    play_round(2'b10);
    check("p1_wins_scores", 32'(bus.Scores), 32'h54);
    bus.Start_Pressed = 1'b1;
    step();
    bus.Start_Pressed = 1'b0;
    check("victory_priority", 32'(bus.gameState), 7);
    check("victory_winner", 32'(bus.Winner), 1);
    check("victory_no_draw", 32'(bus.Draw), 0);
`endif
    tick();
    check("victory_holds", 32'(bus.gameState), 7);
    bus.Confirm_Pressed = 1'b1;
    step();
    bus.Confirm_Pressed = 1'b0;
    check("confirm_title", 32'(bus.gameState), 0);
    press_start();
    check("new_match_scores", 32'(bus.Scores), 0);
    check("new_match_round", 32'(bus.Round_Num), 1);

    // Async reset during Pause_2
    tick();
    tick();
    bus.Hit_Detected = 2'b10;
    step();
    bus.Hit_Detected = 2'b00;
    step();
    check("pre_reset_pause2", 32'(bus.gameState), 6);
    #2;
    Reset = 1'b0;
    #1;
    check("async_state", 32'(bus.gameState), 0);
    check("async_scores", 32'(bus.Scores), 0);
    check("async_round_num", 32'(bus.Round_Num), 0);
    check("async_round_time", 32'(bus.Round_Time), 0);
    step();
    Reset = 1'b1;
    step();
    check("post_reset_title", 32'(bus.gameState), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
